// File: rtl/soc_mgmt_syscfg_apb_demux.sv
// ============================================================================
// Module   : soc_mgmt_syscfg_apb_demux
// Brief    : APB4 1:N demultiplexer for the soc_mgmt syscfg space, with
//            decode-error responses and hung-subordinate timeout termination.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_mgmt_syscfg_apb_demux #(
    parameter int NumSub        = 5,
    parameter int AddrW         = 19,
    parameter int TimeoutCycles = 256,
    localparam int CntW         = $clog2(TimeoutCycles + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    // Manager side
    input  logic [AddrW-1:0]     i_paddr,
    input  logic                 i_psel,
    input  logic                 i_penable,
    input  logic                 i_pwrite,
    input  logic [31:0]          i_pwdata,
    input  logic [3:0]           i_pstrb,
    input  logic [2:0]           i_pprot,
    output logic [31:0]          o_prdata,
    output logic                 o_pready,
    output logic                 o_pslverr,
    // Decoder side
    input  logic [2:0]           i_sub_idx,
    input  logic                 i_dec_err,
    // Subordinate side
    output logic [NumSub-1:0]    o_sub_psel,
    output logic                 o_sub_penable,
    output logic [AddrW-1:0]     o_sub_paddr,
    output logic                 o_sub_pwrite,
    output logic [31:0]          o_sub_pwdata,
    output logic [3:0]           o_sub_pstrb,
    output logic [2:0]           o_sub_pprot,
    input  logic [NumSub*32-1:0] i_sub_prdata,
    input  logic [NumSub-1:0]    i_sub_pready,
    input  logic [NumSub-1:0]    i_sub_pslverr,
    // Status
    output logic                 o_timeout,
    output logic [7:0]           o_err_count
);

    localparam logic [CntW-1:0] c_CNT_LAST = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ERR    = 2'd2,
        S_TOUT   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_nxt;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_nxt;
    logic [7:0]        r_err_count;
    logic              w_err_inc;

    logic              w_setup;
    logic              w_req_ok;
    logic [31:0]       w_sel_rdata;
    logic              w_sel_ready;
    logic              w_sel_err;

    logic [NumSub-1:0] w_sub_psel;
    logic              w_sub_penable;
    logic              w_pready;
    logic              w_pslverr;
    logic [31:0]       w_prdata;
    logic              w_timeout;

    assign w_setup  = i_psel && !i_penable;
    assign w_req_ok = !i_dec_err && (int'(i_sub_idx) < NumSub);

    always_comb begin
        w_sel_rdata = '0;
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        for (int i = 0; i < NumSub; i++) begin
            if (r_idx == 3'(i)) begin
                w_sel_rdata = i_sub_prdata[i*32 +: 32];
                w_sel_ready = i_sub_pready[i];
                w_sel_err   = i_sub_pslverr[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_err_inc && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_err_inc     = 1'b0;
        w_sub_psel    = '0;
        w_sub_penable = 1'b0;
        w_pready      = 1'b0;
        w_pslverr     = 1'b0;
        w_prdata      = '0;
        w_timeout     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_setup) begin
                    if (w_req_ok) begin
                        w_sub_psel  = NumSub'(1) << i_sub_idx;
                        w_idx_nxt   = i_sub_idx;
                        w_state_nxt = S_ACCESS;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_ACCESS: begin
                w_sub_psel    = NumSub'(1) << r_idx;
                w_sub_penable = i_penable;
                w_pready      = w_sel_ready;
                w_pslverr     = w_sel_ready && w_sel_err;
                w_prdata      = w_sel_ready ? w_sel_rdata : 32'h0;
                if (i_penable && w_sel_ready) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (i_penable) begin
                    // Ready seen on the last counted cycle still completes normally.
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = S_TOUT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CntW'(1);
                    end
                end
            end
            S_ERR: begin
                w_pready  = i_penable;
                w_pslverr = i_penable;
                if (i_penable) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_TOUT: begin
                w_pready    = 1'b1;
                w_pslverr   = 1'b1;
                w_timeout   = 1'b1;
                w_err_inc   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Response and select outputs are forced quiet while reset is held.
    assign o_sub_psel    = i_rst_n ? w_sub_psel    : '0;
    assign o_sub_penable = i_rst_n ? w_sub_penable : 1'b0;
    assign o_pready      = i_rst_n ? w_pready      : 1'b0;
    assign o_pslverr     = i_rst_n ? w_pslverr     : 1'b0;
    assign o_prdata      = i_rst_n ? w_prdata      : 32'h0;
    assign o_timeout     = i_rst_n ? w_timeout     : 1'b0;
    assign o_err_count   = r_err_count;

    assign o_sub_paddr  = i_paddr;
    assign o_sub_pwrite = i_pwrite;
    assign o_sub_pwdata = i_pwdata;
    assign o_sub_pstrb  = i_pstrb;
    assign o_sub_pprot  = i_pprot;

endmodule

`default_nettype wire
